// File: rtl/mix_col_enc_seq.sv
// Sequential forward AES MixColumns engine (encryption side).
// Accepts a 128-bit state and round number, transforms one 32-bit column per clock
// and hands back the result. Rounds 0 and 10 pass through untransformed.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input state/round valid
//   in_ready   block idle and able to accept
//   state_in   input state, column c = state_in[127-32c -: 32], byte 0 of a column in [31:24]
//   round_in   AES round number for this state
//   out_valid  result valid
//   out_ready  downstream accepts result
//   state_out  result state, same byte order as state_in
//   round_out  round number captured with the state
module mix_col_enc_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [3:0]   round_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [3:0]   round_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]   fsm_q, fsm_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   round_q, round_d;
  logic [31:0]  col_in, col_out;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    // 3x is computed as 2x ^ x.
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  always_comb begin
    col_in = 32'h0;
    unique case (col_q)
      2'd0: col_in = st_q[127:96];
      2'd1: col_in = st_q[95:64];
      2'd2: col_in = st_q[63:32];
      2'd3: col_in = st_q[31:0];
    endcase
  end

  assign col_out = mix_col(col_in);

  always_comb begin
    fsm_d   = fsm_q;
    col_d   = col_q;
    st_d    = st_q;
    round_d = round_q;
    case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          st_d    = state_in;
          round_d = round_in;
          col_d   = 2'd0;
          // Only the initial and final rounds skip MixColumns; 11..15 are transformed.
          if (round_in == 4'd0 || round_in == 4'd10) begin
            fsm_d = StDone;
          end else begin
            fsm_d = StBusy;
          end
        end
      end
      StBusy: begin
        unique case (col_q)
          2'd0: st_d[127:96] = col_out;
          2'd1: st_d[95:64]  = col_out;
          2'd2: st_d[63:32]  = col_out;
          2'd3: st_d[31:0]   = col_out;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      col_q   <= 2'd0;
      st_q    <= 128'h0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      col_q   <= col_d;
      st_q    <= st_d;
      round_q <= round_d;
    end
  end

  assign in_ready  = (fsm_q == StIdle);
  assign out_valid = (fsm_q == StDone);
  assign state_out = st_q;
  assign round_out = round_q;

endmodule

// File: tb/tb_mix_col_enc_seq.sv
// Self-checking bench for mix_col_enc_seq: directed FIPS-197 vectors, bypass rounds,
// backpressure, reset mid-operation, random round-trip and back-to-back throughput.
module tb_mix_col_enc_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [3:0]   round_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round_out;

  int errors;
  int checks;

  mix_col_enc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_in  (round_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .round_out (round_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column; inv selects the inverse matrix.
  function automatic logic [127:0] mix_model(input logic [127:0] st, input logic [3:0] rnd,
                                             input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (!inv && (rnd == 4'd0 || rnd == 4'd10)) return st;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    res = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = st[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h0;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(base[(k - r + 4) % 4], a[k]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  // Presents one block from a negedge, waits for out_valid (bounded) and optionally hands off.
  // lat counts rising edges after the acceptance edge until out_valid is seen.
  task automatic run_block(input logic [127:0] st, input logic [3:0] rnd, input bit handoff,
                           output logic [127:0] got, output logic [3:0] grnd, output int lat);
    @(negedge clk);
    state_in = st;
    round_in = rnd;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got  = state_out;
    grnd = round_out;
    if (handoff) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  localparam logic [127:0] VecCol  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VecColR = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] VecB    = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] VecBR   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] VecRst  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] VecRstR = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  logic [127:0] got;
  logic [127:0] held;
  logic [127:0] rs;
  logic [3:0]   grnd;
  logic [3:0]   rr;
  int           lat;
  int           cyc;

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    round_in  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_state_out", state_out, 0);
    check_eq("rst_round_out", round_out, 0);
    rst_n = 1'b1;

    // Single-column FIPS vector and latency.
    run_block(VecCol, 4'd1, 1'b1, got, grnd, lat);
    check_eq("col_state", got, VecColR);
    check_eq("col_model", got, mix_model(VecCol, 4'd1, 1'b0));
    check_eq("col_latency", lat, 4);
    check_eq("col_round", grnd, 4'd1);
    check_eq("col_handoff_in_ready", in_ready, 1);
    check_eq("col_handoff_out_valid", out_valid, 0);

    // Full round, FIPS-197 App. B.
    run_block(VecB, 4'd1, 1'b1, got, grnd, lat);
    check_eq("appb_state", got, VecBR);
    check_eq("appb_round", grnd, 4'd1);

    // Bypass rounds 10 and 0, then round 11 is transformed.
    run_block(VecB, 4'd10, 1'b1, got, grnd, lat);
    check_eq("byp10_state", got, VecB);
    check_eq("byp10_latency", lat, 0);
    check_eq("byp10_round", grnd, 4'd10);
    run_block(VecB, 4'd0, 1'b1, got, grnd, lat);
    check_eq("byp0_state", got, VecB);
    check_eq("byp0_latency", lat, 0);
    check_eq("byp0_round", grnd, 4'd0);
    run_block(VecB, 4'd11, 1'b1, got, grnd, lat);
    check_eq("r11_state", got, VecBR);
    check_eq("r11_latency", lat, 4);
    check_eq("r11_round", grnd, 4'd11);

    // Backpressure: hold in DONE while inputs churn.
    run_block(VecCol, 4'd3, 1'b0, held, grnd, lat);
    check_eq("bp_first", held, VecColR);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      state_in = {$urandom, $urandom, $urandom, $urandom};
      round_in = 4'($urandom_range(9, 1));
      @(negedge clk);
      check_eq("bp_state_hold", state_out, held);
      check_eq("bp_round_hold", round_out, 4'd3);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", in_ready, 1);
    check_eq("bp_release_out_valid", out_valid, 0);
    check_eq("bp_not_captured", state_out, held);

    // Reset after the second BUSY edge.
    @(negedge clk);
    state_in = VecB;
    round_in = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_state_out", state_out, 0);
    check_eq("mid_rst_round_out", round_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(VecRst, 4'd2, 1'b1, got, grnd, lat);
    check_eq("post_rst_state", got, VecRstR);
    check_eq("post_rst_latency", lat, 4);

    // Random round-trip through forward then inverse matrix.
    for (int i = 0; i < 1000; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rr = 4'($urandom_range(9, 1));
      run_block(rs, rr, 1'b1, got, grnd, lat);
      check_eq("rt_fwd", got, mix_model(rs, rr, 1'b0));
      check_eq("rt_inv", mix_model(got, rr, 1'b1), rs);
      check_eq("rt_round", grnd, rr);
    end

    // Back-to-back with out_ready tied high: one block every 6 cycles.
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rs       = {$urandom, $urandom, $urandom, $urandom};
      rr       = 4'($urandom_range(9, 1));
      state_in = rs;
      round_in = rr;
      in_valid = 1'b1;
      cyc      = 0;
      while (cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (out_valid) begin
          check_eq("b2b_state", state_out, mix_model(rs, rr, 1'b0));
          check_eq("b2b_round", round_out, rr);
        end
        if (in_ready) break;
      end
      check_eq("b2b_period", cyc, 6);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
